// File: rtl/trace_pkg.sv
// trace_pkg: record layout shared by the change tracer and its FIFO.
// Holds the record width helper, field offsets and the default packed record.
package trace_pkg;

    localparam int WIDTH_DEF = 6;
    localparam int TS_W_DEF  = 16;

    // Record layout, LSB first: value, timestamp, overflow flag.
    localparam int VALUE_LSB = 0;
    localparam int TS_LSB    = WIDTH_DEF;
    localparam int OVF_BIT   = WIDTH_DEF + TS_W_DEF;

    function automatic int rec_w(input int width, input int ts_w);
        return width + ts_w + 1;
    endfunction

    function automatic int ts_lsb(input int width);
        return width;
    endfunction

    function automatic int ovf_bit(input int width, input int ts_w);
        return width + ts_w;
    endfunction

    typedef struct packed {
        logic                ovf;
        logic [TS_W_DEF-1:0] ts;
        logic [WIDTH_DEF-1:0] value;
    } trace_rec_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with extra-MSB pointers; push while full is legal with a same-cycle pop.
// Ports: clk, rst_n (async active-low), push/wdata, pop, rdata (head, 0 when empty), full, empty.
module sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wptr, rptr;
    logic [DW-1:0] mem [DEPTH];
    logic          do_push, do_pop;

    assign empty   = wptr == rptr;
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Storage is not reset, so the head is masked until a record exists.
    assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/change_tracer.sv
// change_tracer: records each change of a sampled bus as a timestamped record on a valid/ready stream.
// Ports: clk, rst_n (async active-low), sample_en/din (monitored bus), out_valid/out_ready (stream
// handshake), out_value/out_ts/out_ovf (head record), drop_cnt (saturating count of dropped records).
module change_tracer
    import trace_pkg::*;
#(
    parameter int WIDTH  = 6,
    parameter int DEPTH  = 8,
    parameter int TS_W   = 16,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_en,
    input  logic [WIDTH-1:0]  din,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_value,
    output logic [TS_W-1:0]   out_ts,
    output logic              out_ovf,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int RW = rec_w(WIDTH, TS_W);

    logic [TS_W-1:0]  ts;
    logic [WIDTH-1:0] prev;
    logic             first, ovf_pend;
    logic             full, empty, change, pop, accept, drop;
    logic [RW-1:0]    rec, head;

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign change    = sample_en && (first || din != prev);
    // A full FIFO still takes the record when the head leaves in the same cycle.
    assign accept    = change && (!full || pop);
    assign drop      = change && !accept;
    assign rec       = {ovf_pend, ts, din};

    assign out_value = head[WIDTH-1:0];
    assign out_ts    = head[ts_lsb(WIDTH) +: TS_W];
    assign out_ovf   = head[ovf_bit(WIDTH, TS_W)];

    sync_fifo #(.DW(RW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .wdata (rec),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts       <= '0;
            prev     <= '0;
            first    <= 1'b1;
            ovf_pend <= 1'b0;
            drop_cnt <= '0;
        end else begin
            ts <= ts + 1'b1;
            // The change reference advances even when the record itself is dropped.
            if (change) begin
                prev  <= din;
                first <= 1'b0;
            end
            ovf_pend <= drop ? 1'b1 : accept ? 1'b0 : ovf_pend;
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_change_tracer.sv
// tb_change_tracer: directed and random stimulus checked against a queue-based record model.
module tb_change_tracer;

    localparam int WIDTH  = 6;
    localparam int DEPTH  = 8;
    localparam int TS_W   = 16;
    localparam int DROP_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sample_en = 1'b0;
    logic [WIDTH-1:0]  din = '0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [WIDTH-1:0]  out_value;
    logic [TS_W-1:0]   out_ts;
    logic              out_ovf;
    logic [DROP_W-1:0] drop_cnt;

    change_tracer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(TS_W), .DROP_W(DROP_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_ts    (out_ts),
        .out_ovf   (out_ovf),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             o;
        logic [TS_W-1:0]  t;
        logic [WIDTH-1:0] v;
    } mrec_t;

    mrec_t            q[$];
    logic [TS_W-1:0]  m_ts;
    logic [WIDTH-1:0] m_prev;
    bit               m_first, m_pend;
    int               m_drop;
    int               checks = 0;
    int               errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_ts    = '0;
        m_prev  = '0;
        m_first = 1'b1;
        m_pend  = 1'b0;
        m_drop  = 0;
    endtask

    // Drive one cycle, advance the model across the edge, then compare on the falling edge.
    task automatic cyc(input bit se, input logic [WIDTH-1:0] d, input bit rdy);
        bit    pop, ch, acc;
        mrec_t r, tmp;
        sample_en = se;
        din       = d;
        out_ready = rdy;
        pop = q.size() > 0 && rdy;
        ch  = se && (m_first || d != m_prev);
        acc = q.size() < DEPTH || pop;
        r   = '{o: m_pend, t: m_ts, v: d};
        if (pop) tmp = q.pop_front();
        if (ch) begin
            if (acc) begin
                q.push_back(r);
                m_pend = 1'b0;
            end else begin
                m_pend = 1'b1;
                if (m_drop < 255) m_drop++;
            end
            m_prev  = d;
            m_first = 1'b0;
        end
        m_ts++;
        @(posedge clk);
        @(negedge clk);
        chk("valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("value", 32'(out_value), 32'(q[0].v));
            chk("ts", 32'(out_ts), 32'(q[0].t));
            chk("ovf", 32'(out_ovf), 32'(q[0].o));
        end
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_value", 32'(out_value), 0);
        chk("rst_ts", 32'(out_ts), 0);
        chk("rst_ovf", 32'(out_ovf), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1);
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        do_reset();

        // Constant input after reset: exactly one record at ts 0.
        cyc(1'b1, 6'd3, 1'b1);
        chk("first_rec_ts", 32'(out_ts), 0);
        chk("first_rec_val", 32'(out_value), 3);
        for (int i = 0; i < 4; i++) cyc(1'b1, 6'd3, 1'b1);
        chk("no_more_recs", 32'(out_valid), 0);

        // Back-to-back changes starting at ts 10.
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b1);
        for (int i = 3; i <= 6; i++) begin
            cyc(1'b1, WIDTH'(i), 1'b1);
            chk("b2b_ts", 32'(out_ts), 32'(i + 7));
        end
        drain(2);

        // Overflow: ten changes with no consumer.
        for (int i = 0; i < 10; i++) cyc(1'b1, WIDTH'(10 + i), 1'b0);
        chk("drop_two", 32'(drop_cnt), 2);
        drain(8);
        chk("drained", 32'(out_valid), 0);
        cyc(1'b1, 6'd40, 1'b1);
        chk("ovf_marked", 32'(out_ovf), 1);
        cyc(1'b1, 6'd41, 1'b1);
        chk("ovf_cleared", 32'(out_ovf), 0);
        drain(2);

        // Push into a full FIFO with a same-cycle pop.
        for (int i = 0; i < 8; i++) cyc(1'b1, WIDTH'(i), 1'b0);
        cyc(1'b1, 6'd20, 1'b1);
        chk("full_push_drop", 32'(drop_cnt), 2);
        drain(9);

        // Disabled sampling, then an unchanged value: no record.
        for (int i = 0; i < 4; i++) cyc(1'b0, WIDTH'(i + 50), 1'b1);
        cyc(1'b1, 6'd20, 1'b1);
        chk("same_no_rec", 32'(out_valid), 0);
        cyc(1'b1, 6'd21, 1'b1);
        chk("diff_rec", 32'(out_valid), 1);
        drain(2);

        // Reset with five queued and three drops total.
        for (int i = 0; i < 9; i++) cyc(1'b1, WIDTH'(30 + i), 1'b0);
        drain(3);
        chk("pre_rst_drop", 32'(drop_cnt), 3);
        do_reset();
        cyc(1'b1, 6'd7, 1'b1);
        chk("post_rst_ts", 32'(out_ts), 0);
        drain(2);

        // Drop counter saturation.
        for (int i = 0; i < 265; i++) cyc(1'b1, WIDTH'(i), 1'b0);
        chk("drop_sat", 32'(drop_cnt), 255);
        drain(9);
        do_reset();

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) do_reset();
            else cyc($urandom_range(3) != 0, WIDTH'($urandom_range(3)), $urandom_range(2) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
